noc_outport_arbiter: RTL

//   Output side of one NoC router direction. Collects the flits that the five
//   per-input routing switches hold for this direction (slot + valid), picks one
//   per cycle round-robin, and drives it onto the link toward the neighbour's input

---
 rtl/noc_pkg.sv | 37 +++
 rtl/noc_rr_arbiter5.sv | 42 ++++
 rtl/noc_outport_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC router definitions used by the output-port arbiters and the
// per-input routing switches.
//   NOC_PORTS            number of router directions (N, E, S, W, Local)
//   DIR_*                direction indices
//   POS_WIDTH            width of one destination coordinate in the flit header
//   dest_x_lsb/dest_y_lsb  header field positions for a given flit width;
//                        dest {x,y} occupies the top 2*POS_WIDTH bits
//   rr_next              round-robin pointer advance with 4 -> 0 wrap
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int NOC_PORTS = 5;

  localparam int DIR_NORTH = 0;
  localparam int DIR_EAST  = 1;
  localparam int DIR_SOUTH = 2;
  localparam int DIR_WEST  = 3;
  localparam int DIR_LOCAL = 4;

  localparam int POS_WIDTH = 4;

  // dest_y sits in the topmost POS_WIDTH bits, dest_x directly below it.
  function automatic int dest_y_lsb(input int data_w);
    return data_w - POS_WIDTH;
  endfunction

  function automatic int dest_x_lsb(input int data_w);
    return data_w - 2 * POS_WIDTH;
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] idx);
    return (idx == 3'(NOC_PORTS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter5.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter5
// Combinational 5-way round-robin pick: the first set request bit at or after
// the pointer position, wrapping 4 -> 0.
// Ports:
//   i_req    [4:0]  request vector
//   i_ptr    [2:0]  highest-priority position (0..4)
//   o_grant  [4:0]  one-hot grant, zero when no request
//   o_idx    [2:0]  index of the granted bit (0 when no request)
// -----------------------------------------------------------------------------
module noc_rr_arbiter5
  import noc_pkg::*;
(
  input  logic [NOC_PORTS-1:0] i_req,
  input  logic [2:0]           i_ptr,
  output logic [NOC_PORTS-1:0] o_grant,
  output logic [2:0]           o_idx
);

  logic [3:0] w_pos;
  logic       w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NOC_PORTS; k++) begin
      // Walk positions ptr, ptr+1, ... modulo 5.
      w_pos = {1'b0, i_ptr} + 4'(k);
      if (w_pos >= 4'(NOC_PORTS)) begin
        w_pos = w_pos - 4'(NOC_PORTS);
      end
      if (!w_found && i_req[w_pos[2:0]]) begin
        w_found            = 1'b1;
        o_grant[w_pos[2:0]] = 1'b1;
        o_idx              = w_pos[2:0];
      end
    end
  end

endmodule

// File: rtl/noc_outport_arbiter.sv
// -----------------------------------------------------------------------------
// noc_outport_arbiter
// Output side of one router direction. Picks one of the flits held by the five
// input switches for this direction each cycle (round-robin), writes it to the
// neighbour's input FIFO and returns a one-cycle clear pulse to the source.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req_data     [NUM_IN][DATA_WIDTH] held flit of each input switch
//   req_valid    [NUM_IN] switch i holds a flit for this direction
//   clear        [NUM_IN] one-cycle consume pulse to the granted switch
//   data_out     [DATA_WIDTH] flit to downstream FIFO write port
//   data_valid   one-cycle write strobe
//   port_busy    downstream FIFO full; blocks new grants
//   flit_count   [31:0] writes issued, saturating (OUTPORT_STATS_EN only)
//   stall_count  [31:0] cycles with pending requests blocked by port_busy,
//                saturating (OUTPORT_STATS_EN only)
// Build option: define OUTPORT_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module noc_outport_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 288,
  parameter int NUM_IN     = 5,
  parameter int DIR        = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0] req_data,
  input  logic [NUM_IN-1:0]                req_valid,
  output logic [NUM_IN-1:0]                clear,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  input  logic                             port_busy
`ifdef OUTPORT_STATS_EN
  ,
  output logic [31:0]                      flit_count,
  output logic [31:0]                      stall_count
`endif
);

  if (NUM_IN != NOC_PORTS || DIR < 0 || DIR >= NOC_PORTS) begin : g_bad_cfg
    $error("noc_outport_arbiter: NUM_IN must be 5 and DIR in 0..4");
  end

  logic [NUM_IN-1:0]     r_clear;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic [2:0]            r_ptr;

  logic [NUM_IN-1:0]     w_elig;
  logic [NUM_IN-1:0]     w_grant;
  logic [2:0]            w_idx;
  logic                  w_take;

  // A switch being cleared this cycle still shows valid until its own
  // register updates; masking it prevents a double grant of the same flit.
  assign w_elig = req_valid & ~r_clear;
  assign w_take = ~port_busy & (|w_elig);

  noc_rr_arbiter5 u_rr (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grant stage -> link/clear registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clear <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_data  <= req_data[w_idx];
      r_valid <= 1'b1;
      r_clear <= w_grant;
      r_ptr   <= rr_next(w_idx);
    end else begin
      r_valid <= 1'b0;
      r_clear <= '0;
    end
  end

  assign clear      = r_clear;
  assign data_out   = r_data;
  assign data_valid = r_valid;

`ifdef OUTPORT_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_flit_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_valid) begin
        r_flit_cnt <= sat_inc32(r_flit_cnt);
      end
      if (port_busy && (|w_elig)) begin
        r_stall_cnt <= sat_inc32(r_stall_cnt);
      end
    end
  end

  assign flit_count  = r_flit_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule
